// File: rtl/coef_bank_pkg.sv
// Shared defaults and state encoding for the coefficient bank sequencer.
package coef_bank_pkg;

    localparam int unsigned DEFAULT_DEPTH = 10;
    localparam int unsigned DEFAULT_WIDTH = 32;
    localparam int unsigned PTR_W         = $clog2(DEFAULT_DEPTH);

    typedef enum logic [1:0] {
        LOAD,
        READY,
        DRAIN
    } seq_state_e;

endpackage

// File: rtl/onehot_encode.sv
// Binary pointer to DEPTH-bit one-hot select; all zero while en is low.
module onehot_encode #(
    parameter int unsigned DEPTH = 10,
    parameter int unsigned PTR_W = 4
) (
    input  logic [PTR_W-1:0] ptr,
    input  logic             en,
    output logic [DEPTH-1:0] onehot
);

    always_comb begin
        onehot = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            onehot[i] = en && (ptr == PTR_W'(i));
        end
    end

endmodule

// File: rtl/coef_bank_sequencer.sv
// Load/playback controller for the one-hot-addressed coefficient register bank.
module coef_bank_sequencer
    import coef_bank_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             start,
    input  logic             reload,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic [DEPTH-1:0] bank_wsel,
    output logic [WIDTH-1:0] bank_wdata,
    output logic [DEPTH-1:0] bank_rsel,
    input  logic [WIDTH-1:0] bank_rdata,
    output logic             loaded
);

    localparam int unsigned         PTR_BITS = $clog2(DEPTH);
    localparam logic [PTR_BITS-1:0] LAST_PTR = PTR_BITS'(DEPTH - 1);
    localparam logic [PTR_BITS-1:0] PTR_ONE  = PTR_BITS'(1);

    seq_state_e          state_q, state_d;
    logic [PTR_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0]    wdata_q, wdata_d;
    logic [DEPTH-1:0]    wsel_q, wsel_d;
    logic [DEPTH-1:0]    rsel_q, rsel_d;
    logic                accept;
    logic                rsel_en;

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        wdata_d  = wdata_q;
        accept   = 1'b0;
        unique case (state_q)
            LOAD: begin
                accept = in_valid;
                if (in_valid) begin
                    wdata_d = in_data;
                    if (wr_ptr_q == LAST_PTR) begin
                        wr_ptr_d = '0;
                        state_d  = READY;
                    end else begin
                        wr_ptr_d = wr_ptr_q + PTR_ONE;
                    end
                end
            end
            READY: begin
                if (reload) begin
                    state_d = LOAD;
                end else if (start) begin
                    state_d  = DRAIN;
                    rd_ptr_d = '0;
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    if (rd_ptr_q == LAST_PTR) begin
                        state_d  = READY;
                        rd_ptr_d = '0;
                    end else begin
                        rd_ptr_d = rd_ptr_q + PTR_ONE;
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    // Selects are computed from next-state values and then registered, so the
    // read select stays put whenever the consumer stalls.
    assign rsel_en = (state_d == DRAIN);

    onehot_encode #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_BITS)
    ) u_wsel_enc (
        .ptr    (wr_ptr_q),
        .en     (accept),
        .onehot (wsel_d)
    );

    onehot_encode #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_BITS)
    ) u_rsel_enc (
        .ptr    (rd_ptr_d),
        .en     (rsel_en),
        .onehot (rsel_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= LOAD;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            wdata_q  <= '0;
            wsel_q   <= '0;
            rsel_q   <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            wdata_q  <= wdata_d;
            wsel_q   <= wsel_d;
            rsel_q   <= rsel_d;
        end
    end

    assign in_ready   = (state_q == LOAD) && !reset;
    assign out_valid  = (state_q == DRAIN) && !reset;
    assign out_last   = out_valid && (rd_ptr_q == LAST_PTR);
    assign loaded     = ((state_q == READY) || (state_q == DRAIN)) && !reset;
    assign out_data   = bank_rdata;
    assign bank_wsel  = wsel_q;
    assign bank_wdata = wdata_q;
    assign bank_rsel  = rsel_q;

endmodule

// File: tb/tb_coef_bank_sequencer.sv
// Bench for coef_bank_sequencer: behavioural bank, write/read scoreboard, directed sequences.
module tb_coef_bank_sequencer;

    localparam int DEPTH = 10;
    localparam int WIDTH = 32;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             start;
    logic             reload;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic [DEPTH-1:0] bank_wsel;
    logic [WIDTH-1:0] bank_wdata;
    logic [DEPTH-1:0] bank_rsel;
    logic [WIDTH-1:0] bank_rdata;
    logic             loaded;

    coef_bank_sequencer #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .start      (start),
        .reload     (reload),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .bank_wsel  (bank_wsel),
        .bank_wdata (bank_wdata),
        .bank_rsel  (bank_rsel),
        .bank_rdata (bank_rdata),
        .loaded     (loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 10x32 bank
    logic [WIDTH-1:0] mem [DEPTH];

    always @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (bank_wsel[i]) mem[i] <= bank_wdata;
        end
    end

    always_comb begin
        bank_rdata = 'x;
        for (int i = 0; i < DEPTH; i++) begin
            if (bank_rsel[i]) bank_rdata = mem[i];
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard
    typedef struct packed {
        logic [DEPTH-1:0] sel;
        logic [WIDTH-1:0] data;
    } wr_exp_t;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             last;
    } rd_exp_t;

    wr_exp_t          wq[$];
    rd_exp_t          rq[$];
    logic [WIDTH-1:0] ref_mem [DEPTH];
    int               wcnt = 0;
    logic             mon_en = 1'b0;

    always @(negedge clk) begin
        wr_exp_t we;
        rd_exp_t re;
        if (mon_en) begin
            if (wq.size() > 0) begin
                we = wq.pop_front();
                check("sb_wsel", 32'(bank_wsel), 32'(we.sel));
                check("sb_wdata", bank_wdata, we.data);
            end else begin
                check("sb_wsel_idle", 32'(bank_wsel), 32'h0);
            end
            if (in_valid && in_ready) begin
                wq.push_back('{sel: (10'b1 << wcnt), data: in_data});
                ref_mem[wcnt] = in_data;
                wcnt = (wcnt == DEPTH - 1) ? 0 : wcnt + 1;
            end
            if (out_valid && out_ready) begin
                if (rq.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL sb_rd_unexpected: got word %h expected none", out_data);
                end else begin
                    re = rq.pop_front();
                    check("sb_out_data", out_data, re.data);
                    check("sb_out_last", 32'(out_last), 32'(re.last));
                end
            end
            if (loaded && !out_valid && start && !reload && !reset) begin
                for (int k = 0; k < DEPTH; k++) begin
                    rq.push_back('{data: ref_mem[k], last: (k == DEPTH - 1)});
                end
            end
            if (reset) begin
                wq.delete();
                rq.delete();
                wcnt = 0;
            end
        end
    end

    typedef struct packed {
        logic             vld;
        logic [WIDTH-1:0] data;
        logic             exp_in_ready;
        logic [DEPTH-1:0] exp_wsel;
        logic             exp_loaded;
    } load_vec_t;

    load_vec_t vecs [20];

    task automatic load_held(input logic [31:0] base);
        for (int k = 0; k < DEPTH; k++) begin
            in_valid = 1'b1;
            in_data  = base + 32'(k);
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic playback(input string tag, input logic [31:0] base);
        start     = 1'b1;
        out_ready = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < DEPTH; c++) begin
            check({tag, "_valid"}, 32'(out_valid), 32'h1);
            check({tag, "_data"}, out_data, base + 32'(c));
            check({tag, "_last"}, 32'(out_last), 32'(c == DEPTH - 1));
            tick();
        end
        check({tag, "_done_valid"}, 32'(out_valid), 32'h0);
        check({tag, "_done_loaded"}, 32'(loaded), 32'h1);
        check({tag, "_done_rsel"}, 32'(bank_rsel), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        start     = 1'b0;
        reload    = 1'b0;
        out_ready = 1'b0;

        for (int i = 0; i < 20; i++) begin
            vecs[i].vld          = (i % 2 == 0) && (i < 19);
            vecs[i].data         = vecs[i].vld ? 32'h100 + 32'(i / 2) : 32'hdead_0000 + 32'(i);
            vecs[i].exp_in_ready = (i <= 18);
            vecs[i].exp_wsel     = (i % 2 == 1) ? (10'b1 << ((i - 1) / 2)) : 10'b0;
            vecs[i].exp_loaded   = (i == 19);
        end

        repeat (3) tick();
        check("rst_in_ready", 32'(in_ready), 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_last", 32'(out_last), 32'h0);
        check("rst_loaded", 32'(loaded), 32'h0);
        check("rst_wsel", 32'(bank_wsel), 32'h0);
        check("rst_wdata", bank_wdata, 32'h0);
        check("rst_rsel", 32'(bank_rsel), 32'h0);
        reset  = 1'b0;
        mon_en = 1'b1;
        tick();
        check("load_in_ready", 32'(in_ready), 32'h1);

        // Held load
        load_held(32'h100);
        check("held_loaded", 32'(loaded), 32'h1);
        check("held_in_ready", 32'(in_ready), 32'h0);
        check("held_last_wsel", 32'(bank_wsel), 32'h200);
        tick();
        for (int k = 0; k < DEPTH; k++) check("held_mem", mem[k], 32'h100 + 32'(k));

        reload = 1'b1;
        tick();
        reload = 1'b0;
        check("reload_in_ready", 32'(in_ready), 32'h1);
        check("reload_loaded", 32'(loaded), 32'h0);

        // Gapped load, table driven
        for (int i = 0; i < 20; i++) begin
            check("tbl_in_ready", 32'(in_ready), 32'(vecs[i].exp_in_ready));
            check("tbl_wsel", 32'(bank_wsel), 32'(vecs[i].exp_wsel));
            check("tbl_loaded", 32'(loaded), 32'(vecs[i].exp_loaded));
            in_valid = vecs[i].vld;
            in_data  = vecs[i].data;
            tick();
        end
        in_valid = 1'b0;
        for (int k = 0; k < DEPTH; k++) check("tbl_mem", mem[k], 32'h100 + 32'(k));

        playback("pb", 32'h100);

        // Stall on word 4
        start     = 1'b1;
        out_ready = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < DEPTH; c++) begin
            check("stl_data", out_data, 32'h100 + 32'(c));
            if (c == 4) begin
                out_ready = 1'b0;
                repeat (3) begin
                    tick();
                    check("stl_hold_valid", 32'(out_valid), 32'h1);
                    check("stl_hold_data", out_data, 32'h104);
                    check("stl_hold_rsel", 32'(bank_rsel), 32'h010);
                end
                out_ready = 1'b1;
            end
            tick();
        end
        check("stl_done_valid", 32'(out_valid), 32'h0);

        // start and reload together: reload wins
        start  = 1'b1;
        reload = 1'b1;
        tick();
        start  = 1'b0;
        reload = 1'b0;
        check("both_out_valid", 32'(out_valid), 32'h0);
        check("both_in_ready", 32'(in_ready), 32'h1);
        check("both_loaded", 32'(loaded), 32'h0);
        load_held(32'h200);
        check("new_in_ready", 32'(in_ready), 32'h0);
        tick();
        playback("new", 32'h200);
        check("sb_rq_empty", 32'(rq.size()), 32'h0);
        check("sb_wq_empty", 32'(wq.size()), 32'h0);

        // Reset in the middle of a playback
        start     = 1'b1;
        out_ready = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 6; c++) begin
            check("mid_data", out_data, 32'h200 + 32'(c));
            tick();
        end
        check("mid_word6", out_data, 32'h206);
        out_ready = 1'b0;
        reset     = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'h0);
        check("mid_rst_rsel", 32'(bank_rsel), 32'h0);
        check("mid_rst_in_ready", 32'(in_ready), 32'h1);
        check("mid_rst_loaded", 32'(loaded), 32'h0);
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/coef_bank_sequencer.md
Name: coef_bank_sequencer

Overview:
- Access controller for the 10x32 one-hot-addressed coefficient register bank.
- Write side: accepts a valid/ready stream of DEPTH words and writes them into consecutive bank entries by driving a one-hot wsel.
- Read side: on request, plays the bank back as a valid/ready stream by driving a one-hot rsel and forwarding the bank's dout.
- Sits between the coefficient producer (e.g. LPC analysis) and the consumer (synthesis filter). The bank is a separate instance.

Parameters:
- DEPTH, 10, number of bank entries; wsel/rsel width.
- WIDTH, 32, data word width.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- in_valid  in  1  producer word valid
- in_ready  out  1  sequencer accepts word
- in_data  in  WIDTH  producer word
- start  in  1  playback request (sampled in READY)
- reload  in  1  return to LOAD (sampled in READY)
- out_valid  out  1  playback word valid
- out_ready  in  1  consumer accepts word
- out_data  out  WIDTH  playback word
- out_last  out  1  marks word DEPTH-1 of a playback
- bank_wsel  out  DEPTH  one-hot write select to bank, registered
- bank_wdata  out  WIDTH  write data to bank, registered
- bank_rsel  out  DEPTH  one-hot read select to bank, registered
- bank_rdata  in  WIDTH  bank dout (combinational from bank_rsel)
- loaded  out  1  high while bank holds a complete set (READY or DRAIN)

Behaviour:
- States: LOAD, READY, DRAIN. Pointers wr_ptr and rd_ptr, each 0..DEPTH-1, 4 bits at default.
- Reset values:
  - State: LOAD; wr_ptr = rd_ptr = 0.
  - bank_wsel = 0, bank_wdata = 0, bank_rsel = 0.
  - out_valid = 0, out_last = 0, loaded = 0, in_ready = 0 during reset.
- LOAD:
  - in_ready = 1.
  - On in_valid & in_ready at edge N: bank_wsel = 1<<wr_ptr and bank_wdata = in_data during cycle N+1, so the bank captures at edge N+1; wr_ptr increments.
  - bank_wsel = 0 in every cycle following a non-accept. There is never more than one hot bit.
  - Acceptance with wr_ptr = DEPTH-1: wr_ptr wraps to 0 and state goes to READY at the same edge. The pending write still issues in the first READY cycle.
- READY:
  - in_ready = 0, out_valid = 0, loaded = 1.
  - reload = 1: go to LOAD next cycle. reload has priority over start.
  - Otherwise start = 1: go to DRAIN with rd_ptr = 0 and bank_rsel = 1<<0 registered at that edge.
- DRAIN:
  - out_valid = 1; out_data = bank_rdata (combinational passthrough).
  - out_last = 1 when rd_ptr = DEPTH-1.
  - bank_rsel is held stable while out_ready = 0, so out_data remains stable (AXI-style no-retract rule).
  - On out_valid & out_ready: rd_ptr increments and bank_rsel shifts to the next one-hot.
  - Handshake on the last word: go to READY, bank_rsel = 0, rd_ptr = 0. Coefficients are retained, so replay via start is allowed.
  - start and reload are ignored in DRAIN. in_valid is ignored outside LOAD.
- Throughput:
  - One word per cycle in both directions.
  - First playback word is valid one cycle after start is sampled.
  - Earliest DRAIN read of entry 0 follows its write by at least DEPTH cycles, so there is no read-before-write hazard.
- Reset mid-operation: state returns to LOAD and all outputs go to reset values on the next edge. A partially loaded set is discarded logically. The bank contents are not touched by this block.
- bank_rsel = 0 outside DRAIN. The bank returns X for rsel = 0; out_valid = 0 masks it.

Decomposition:
- Package coef_bank_pkg:
  - DEPTH/WIDTH defaults.
  - State enum {LOAD, READY, DRAIN}.
  - PTR_W = clog2(DEPTH).
- One sub-module: onehot_encode (ptr -> DEPTH-bit one-hot, zero when the enable input is low). Instantiated twice, for wsel and rsel.

Test Plan:
- Load 0x100..0x109 with in_valid held -> bank_wsel walks 0x001..0x200 one cycle after each accept; entry k = 0x100+k; READY after 10 accepts; loaded = 1.
- Load with in_valid toggling every other cycle -> bank_wsel = 0 in idle cycles; still exactly 10 writes; same contents.
- start in READY, out_ready = 1 -> out_data 0x100..0x109 on 10 consecutive cycles; out_last only with 0x109; state READY afterward.
- Playback with out_ready low for 3 cycles on word 4 -> out_data holds 0x104 and bank_rsel holds 0x010 throughout; resumes at 0x105.
- start and reload asserted together in READY -> LOAD entered, no out_valid; a new load of 0x200..0x209 followed by replay returns the new values.
- reset asserted mid-DRAIN at word 6 -> next cycle out_valid = 0, bank_rsel = 0, in_ready = 1, loaded = 0.
